// File: rtl/muldiv_ctrl.sv
// E-stage sequencer for the shared multi-cycle multiplier/divider: launch, accumulate, hold, single HI/LO write.
// Optional: define DIV_ZERO_BYPASS_EN to resolve divide-by-zero locally without launching the divider.
module muldiv_ctrl #(
  parameter int unsigned MAX_CYCLES = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_kind,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] hilo_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        flush_exc_i,
  output logic        mul_start_o,
  output logic        mul_sign_o,
  input  logic        mul_ready_i,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_sign_o,
  output logic        div_annul_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        busy_o,
  output logic        hilo_we_o,
  output logic [63:0] hilo_wdata_o,
  output logic        timeout_o
);

  localparam int unsigned RES_W = 64;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  // op class from op_kind[2:1]
  localparam logic [1:0] CLS_MUL = 2'b00;
  localparam logic [1:0] CLS_DIV = 2'b01;
  localparam logic [1:0] CLS_MAC = 2'b10;
  localparam logic [1:0] CLS_MSB = 2'b11;

  state_e             state_q, state_d;
  logic [1:0]         cls_q, cls_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               mul_start_q, mul_start_d;
  logic               div_start_q, div_start_d;
  logic               mul_sign_q, mul_sign_d;
  logic               div_sign_q, div_sign_d;
  logic               annul_q, annul_d;

  logic               launch_div;
  logic               run_is_div;
  logic               sel_ready;
  logic               bypass;
  logic [RES_W-1:0]   run_result;

  assign launch_div = (op_kind[2:1] == CLS_DIV);
  assign run_is_div = (cls_q == CLS_DIV);
  assign sel_ready  = run_is_div ? div_ready_i : mul_ready_i;

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = launch_div && (src_b == 32'h0);
`else
  logic unused_operands;
  assign bypass          = 1'b0;
  assign unused_operands = ^{src_a, src_b};
`endif

  // result selection including the MADD/MSUB accumulate against the live HI/LO
  always_comb begin
    run_result = mul_result_i;
    unique case (cls_q)
      CLS_MUL: run_result = mul_result_i;
      CLS_DIV: run_result = div_result_i;
      CLS_MAC: run_result = hilo_i + mul_result_i;
      CLS_MSB: run_result = hilo_i - mul_result_i;
      default: run_result = mul_result_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cls_q       <= 2'b00;
      res_q       <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      mul_sign_q  <= 1'b0;
      div_sign_q  <= 1'b0;
      annul_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      mul_sign_q  <= mul_sign_d;
      div_sign_q  <= div_sign_d;
      annul_q     <= annul_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    mul_start_d  = 1'b0;
    div_start_d  = 1'b0;
    mul_sign_d   = mul_sign_q;
    div_sign_d   = div_sign_q;
    annul_d      = 1'b0;
    busy_o       = 1'b0;
    hilo_we_o    = 1'b0;
    hilo_wdata_o = '0;

    unique case (state_q)
      S_IDLE: begin
        busy_o = op_valid;
        if (op_valid && !flush_i) begin
          cls_d = op_kind[2:1];
          cnt_d = '0;
          if (bypass) begin
            res_d   = {src_a, 32'hFFFF_FFFF};
            state_d = S_DONE;
          end else begin
            mul_start_d = !launch_div;
            div_start_d = launch_div;
            mul_sign_d  = !launch_div && !op_kind[0];
            div_sign_d  = launch_div && !op_kind[0];
            state_d     = S_RUN;
          end
        end
      end

      S_RUN: begin
        busy_o = 1'b1;
        if (cnt_q < CNT_W'(MAX_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(MAX_CYCLES)) timeout_d = 1'b1;
        // flush beats a same-cycle ready; an in-flight divide must be annulled
        if (flush_i) begin
          annul_d    = run_is_div;
          res_d      = '0;
          mul_sign_d = 1'b0;
          div_sign_d = 1'b0;
          state_d    = S_IDLE;
        end else if (sel_ready) begin
          res_d      = run_result;
          mul_sign_d = 1'b0;
          div_sign_d = 1'b0;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        hilo_wdata_o = res_q;
        hilo_we_o    = !stall_i && !flush_exc_i && !flush_i;
        if (flush_i || !stall_i) begin
          res_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mul_start_o = mul_start_q;
  assign div_start_o = div_start_q;
  assign mul_sign_o  = mul_sign_q;
  assign div_sign_o  = div_sign_q;
  assign div_annul_o = annul_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: table of back-to-back ops plus directed flush/stall/timeout sequences.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_kind;
  logic [31:0] src_a, src_b;
  logic [63:0] hilo_i;
  logic        stall_i, flush_i, flush_exc_i;
  logic        mul_start_o, mul_sign_o, mul_ready_i;
  logic [63:0] mul_result_i;
  logic        div_start_o, div_sign_o, div_annul_o, div_ready_i;
  logic [63:0] div_result_i;
  logic        busy_o, hilo_we_o, timeout_o;
  logic [63:0] hilo_wdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

  muldiv_ctrl #(.MAX_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_kind(op_kind),
    .src_a(src_a), .src_b(src_b), .hilo_i(hilo_i), .stall_i(stall_i),
    .flush_i(flush_i), .flush_exc_i(flush_exc_i),
    .mul_start_o(mul_start_o), .mul_sign_o(mul_sign_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i),
    .div_start_o(div_start_o), .div_sign_o(div_sign_o), .div_annul_o(div_annul_o),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .busy_o(busy_o), .hilo_we_o(hilo_we_o), .hilo_wdata_o(hilo_wdata_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    int          k;
    int          stall;
    logic [63:0] unit_res;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; op_kind = 3'd0; src_a = '0; src_b = '0; hilo_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; flush_exc_i = 1'b0;
    mul_ready_i = 1'b0; mul_result_i = '0; div_ready_i = 1'b0; div_result_i = '0;
  endtask

  // advance to 1ns after the next rising edge; caller drives, then waits #1 to sample
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // one op from IDLE through its retiring write; unit answers k cycles after start
  task automatic run_op(input int idx, input vec_t v);
    int busy_n = 0, we_n = 0, mst = 0, dst = 0;
    logic [63:0] wd = '0;
    bit is_div;
    int last;
    is_div = (v.kind[2:1] == 2'b01);
    last   = 2 + v.k + v.stall;
    for (int cyc = 0; cyc <= last; cyc++) begin
      next_cycle();
      op_valid = 1'b1; op_kind = v.kind; src_a = v.a; src_b = v.b;
      flush_i = 1'b0; flush_exc_i = 1'b0;
      stall_i = (cyc >= 2 + v.k) && (cyc < 2 + v.k + v.stall);
      hilo_i  = (cyc == 1 + v.k) ? v.hilo : JUNK;
      mul_ready_i = 1'b0; mul_result_i = JUNK;
      div_ready_i = 1'b0; div_result_i = JUNK;
      if (cyc == 1 + v.k) begin
        if (is_div) begin div_ready_i = 1'b1; div_result_i = v.unit_res; end
        else        begin mul_ready_i = 1'b1; mul_result_i = v.unit_res; end
      end else if (cyc == 1 && v.k > 0) begin
        if (is_div) mul_ready_i = 1'b1;
        else        div_ready_i = 1'b1;
      end
      #1;
      if (busy_o) busy_n++;
      if (mul_start_o) mst++;
      if (div_start_o) dst++;
      if (hilo_we_o) begin we_n++; wd = hilo_wdata_o; end
      if (cyc == 1) begin
        if (is_div) chk($sformatf("vec%0d div_sign", idx), 64'(div_sign_o), 64'(!v.kind[0]));
        else        chk($sformatf("vec%0d mul_sign", idx), 64'(mul_sign_o), 64'(!v.kind[0]));
      end
    end
    chk($sformatf("vec%0d busy_cycles", idx), 64'(busy_n), 64'(2 + v.k));
    chk($sformatf("vec%0d write_count", idx), 64'(we_n), 64'd1);
    chk($sformatf("vec%0d wdata", idx), wd, v.exp_wdata);
    chk($sformatf("vec%0d mul_starts", idx), 64'(mst), is_div ? 64'd0 : 64'd1);
    chk($sformatf("vec%0d div_starts", idx), 64'(dst), is_div ? 64'd1 : 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 32'hFFFF_FFFD, 32'd5, JUNK, 2, 0,
                64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[1] = '{3'b101, 32'd1, 32'd1, 64'h0000_0001_FFFF_FFFF, 1, 0,
                64'h1, 64'h0000_0002_0000_0000};
    vecs[2] = '{3'b011, 32'd100, 32'd7, JUNK, 4, 3,
                {32'd2, 32'd14}, {32'd2, 32'd14}};
    vecs[3] = '{3'b110, 32'd2, 32'd3, 64'h10, 0, 0, 64'd6, 64'hA};
    vecs[4] = '{3'b111, 32'd1, 32'd1, 64'h0, 3, 0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{3'b100, 32'hFFFF_FFFE, 32'd4, 64'd5, 2, 1,
                64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[6] = '{3'b010, 32'hFFFF_FFF9, 32'd2, JUNK, 5, 0,
                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[7] = '{3'b001, 32'hFFFF_FFFF, 32'd2, JUNK, 1, 0,
                64'h0000_0001_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE};

    idle_inputs();
    rst = 1'b0;
    op_valid = 1'b1;
    #12;
    chk("reset busy", 64'(busy_o), 64'd1);
    chk("reset we", 64'(hilo_we_o), 64'd0);
    chk("reset wdata", hilo_wdata_o, 64'd0);
    chk("reset starts", {62'd0, mul_start_o, div_start_o}, 64'd0);
    chk("reset annul/timeout", {62'd0, div_annul_o, timeout_o}, 64'd0);
    op_valid = 1'b0;
    next_cycle();
    rst = 1'b1;

    // back-to-back ops, no idle cycles between them
    for (int i = 0; i < 8; i++) run_op(i, vecs[i]);

    // divide flushed two cycles after start
    next_cycle(); idle_inputs(); op_valid = 1'b1; op_kind = 3'b010; src_a = 32'd50; src_b = 32'd3;
    #1; chk("dflush launch busy", 64'(busy_o), 64'd1);
    next_cycle(); #1; chk("dflush start", 64'(div_start_o), 64'd1);
    next_cycle(); #1; chk("dflush start once", 64'(div_start_o), 64'd0);
    next_cycle(); flush_i = 1'b1; #1; chk("dflush we", 64'(hilo_we_o), 64'd0);
    next_cycle(); flush_i = 1'b0; op_valid = 1'b0; div_ready_i = 1'b1; div_result_i = JUNK;
    #1;
    chk("dflush annul", 64'(div_annul_o), 64'd1);
    chk("dflush idle busy", 64'(busy_o), 64'd0);
    chk("dflush no write", 64'(hilo_we_o), 64'd0);
    next_cycle(); div_ready_i = 1'b0; #1;
    chk("dflush annul pulse", 64'(div_annul_o), 64'd0);
    chk("dflush late ready ignored", 64'(hilo_we_o), 64'd0);

    // flushed multiply, then a fresh multiply restarts cleanly
    next_cycle(); idle_inputs(); op_valid = 1'b1; op_kind = 3'b000; src_a = 32'd9; src_b = 32'd9;
    next_cycle(); next_cycle(); flush_i = 1'b1; #1;
    chk("mflush we", 64'(hilo_we_o), 64'd0);
    next_cycle(); idle_inputs(); #1;
    chk("mflush no annul", 64'(div_annul_o), 64'd0);
    run_op(8, '{3'b000, 32'd9, 32'd9, JUNK, 1, 0, 64'd81, 64'd81});

    // ready and flush in the same cycle
    next_cycle(); idle_inputs(); op_valid = 1'b1; op_kind = 3'b010; src_a = 32'd8; src_b = 32'd2;
    next_cycle();
    next_cycle(); div_ready_i = 1'b1; div_result_i = 64'd4; flush_i = 1'b1; #1;
    chk("rdyflush we", 64'(hilo_we_o), 64'd0);
    next_cycle(); idle_inputs(); #1;
    chk("rdyflush no write", 64'(hilo_we_o), 64'd0);
    chk("rdyflush annul", 64'(div_annul_o), 64'd1);
    chk("rdyflush idle", 64'(busy_o), 64'd0);

    // exception flush while in DONE
    next_cycle(); idle_inputs(); op_valid = 1'b1; op_kind = 3'b011; src_a = 32'd9; src_b = 32'd4;
    next_cycle(); div_ready_i = 1'b1; div_result_i = {32'd1, 32'd2};
    next_cycle(); div_ready_i = 1'b0; div_result_i = JUNK; flush_exc_i = 1'b1; #1;
    chk("exc done wdata", hilo_wdata_o, {32'd1, 32'd2});
    chk("exc done we", 64'(hilo_we_o), 64'd0);
    next_cycle(); idle_inputs(); #1;
    chk("exc after we", 64'(hilo_we_o), 64'd0);
    chk("exc after wdata", hilo_wdata_o, 64'd0);

`ifdef DIV_ZERO_BYPASS_EN
    next_cycle(); idle_inputs(); op_valid = 1'b1; op_kind = 3'b011; src_a = 32'h1234_5678; src_b = 32'd0;
    #1; chk("bypass busy0", 64'(busy_o), 64'd1);
    next_cycle(); #1;
    chk("bypass no start", 64'(div_start_o), 64'd0);
    chk("bypass busy1", 64'(busy_o), 64'd0);
    chk("bypass we", 64'(hilo_we_o), 64'd1);
    chk("bypass wdata", hilo_wdata_o, 64'h1234_5678_FFFF_FFFF);
    next_cycle(); idle_inputs(); #1;
    chk("bypass single write", 64'(hilo_we_o), 64'd0);
`else
    run_op(9, '{3'b011, 32'h1234_5678, 32'd0, JUNK, 2, 0,
                64'h1234_5678_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF});
`endif

    // watchdog: unit never answers
    next_cycle(); idle_inputs(); op_valid = 1'b1; op_kind = 3'b001; src_a = 32'd3; src_b = 32'd3;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      next_cycle(); #1;
      if (cyc == 10) chk("timeout early", 64'(timeout_o), 64'd0);
    end
    chk("timeout set", 64'(timeout_o), 64'd1);
    chk("timeout still busy", 64'(busy_o), 64'd1);
    next_cycle(); flush_i = 1'b1;
    next_cycle(); idle_inputs(); #1;
    chk("timeout sticky", 64'(timeout_o), 64'd1);
    rst = 1'b0; op_valid = 1'b1; #1;
    chk("timeout cleared", 64'(timeout_o), 64'd0);
    chk("reset2 busy", 64'(busy_o), 64'd1);
    chk("reset2 we", 64'(hilo_we_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
